aes_key_sched_ctrl: RTL

Sequential AES key-schedule controller. It accepts a cipher key through a valid/ready handshake and iteratively generates the expanded key, one 32-bit word per cycle, into an internal round-key store. It then serves 128-bit round keys by round index to the round datapath. It replaces the fully unrolled expansion chain where area matters, and supports AES-128, AES-192 and AES-256 via parameter.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox.sv | 21 ++
 rtl/key_word_step.sv | 35 +++
 rtl/aes_key_sched_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES key-schedule controller:
// state encoding, round-constant arithmetic and legal key/round pairings.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic bit legal_cfg(input int key_size, input int nr);
    return (key_size == 128 && nr == 10) ||
           (key_size == 192 && nr == 12) ||
           (key_size == 256 && nr == 14);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table (entry 0 in the top byte).
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at byte position 255-a, i.e. bit offset {~a, 3'b000}.
  assign out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/key_word_step.sv
// One key-expansion step: derives w[i] from w[i-1], w[i-NK], i mod NK and rcon.
module key_word_step (
  input  logic [31:0] w_prev_i,
  input  logic [31:0] w_nk_i,
  input  logic [2:0]  i_mod_i,
  input  logic [7:0]  rcon_i,
  input  logic [3:0]  nk_i,
  output logic [31:0] w_next_o
);

  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;

  assign sub_in = (i_mod_i == 3'd0) ? {w_prev_i[23:0], w_prev_i[31:24]} : w_prev_i;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sub_in[8*b +: 8]),
      .out_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = w_prev_i;
    if (i_mod_i == 3'd0) begin
      temp = sub_out ^ {rcon_i, 24'h000000};
    end else if (nk_i == 4'd8 && i_mod_i == 3'd4) begin
      temp = sub_out;
    end
  end

  assign w_next_o = w_nk_i ^ temp;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES key-schedule controller: expands one 32-bit word per cycle
// into a word store and serves registered 128-bit round keys by index.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_SIZE = 128,
  parameter int NR       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic                busy,
  output logic                keys_valid,
  input  logic [3:0]          rk_addr,
  output logic [127:0]        rk_out
);

  localparam int NK = KEY_SIZE / 32;
  localparam int TW = 4 * (NR + 1);
  localparam int AW = $clog2(TW);

  if (!legal_cfg(KEY_SIZE, NR)) begin : g_cfg_check
    $error("aes_key_sched_ctrl: illegal KEY_SIZE/NR pair");
  end

  state_e              state_q;
  logic                key_ready_q;
  logic                busy_q;
  logic                keys_valid_q;
  logic [AW-1:0]       i_q;
  logic [2:0]          mod_q;
  logic [7:0]          rcon_q;
  logic [32*NK-1:0]    win_q;
  logic [31:0]         store_q [TW];
  logic [127:0]        rk_out_q;
  logic [31:0]         word_d;
  logic                accept;
  logic [3:0]          rk_sel;
  logic [AW-1:0]       rd_base;

  assign accept = key_valid && key_ready_q;

  key_word_step u_step (
    .w_prev_i (win_q[31:0]),
    .w_nk_i   (win_q[32*NK-1 -: 32]),
    .i_mod_i  (mod_q),
    .rcon_i   (rcon_q),
    .nk_i     (4'(NK)),
    .w_next_o (word_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      i_q          <= '0;
      mod_q        <= 3'd0;
      rcon_q       <= RCON_INIT;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          key_ready_q <= 1'b1;
          if (accept) begin
            state_q      <= ST_EXPAND;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
            i_q          <= AW'(NK);
            mod_q        <= 3'd0;
            rcon_q       <= RCON_INIT;
          end
        end
        ST_EXPAND: begin
          i_q   <= i_q + AW'(1);
          mod_q <= (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == AW'(TW - 1)) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b1;
            key_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Store and window carry no reset: keys_valid gates every read of them.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= key_in;
      for (int k = 0; k < NK; k++) begin
        store_q[k] <= key_in[KEY_SIZE-1-32*k -: 32];
      end
    end else if (state_q == ST_EXPAND) begin
      win_q        <= {win_q[32*NK-33:0], word_d};
      store_q[i_q] <= word_d;
    end
  end

  assign rk_sel  = (rk_addr > 4'(NR)) ? 4'd0 : rk_addr;
  assign rd_base = AW'({rk_sel, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out_q <= '0;
    end else if (keys_valid_q && rk_addr <= 4'(NR)) begin
      rk_out_q <= {store_q[rd_base], store_q[rd_base + AW'(1)],
                   store_q[rd_base + AW'(2)], store_q[rd_base + AW'(3)]};
    end else begin
      rk_out_q <= '0;
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign rk_out     = rk_out_q;

endmodule
